// File: rtl/audio_pkg.sv
// Shared audio constants and the mix-word to PCM conversion.
// Used by the I2S transmitter; intended for reuse by other audio output paths.
package audio_pkg;

  localparam int PCM_BITS              = 16;
  localparam int MIX_BITS              = 9;
  localparam int I2S_SLOT_BITS_DEFAULT = 32;

  typedef logic [PCM_BITS-1:0] pcm_t;
  typedef logic [MIX_BITS-1:0] mix_t;

  // Excess-256 to two's complement, scaled into the top of a 16-bit word.
  function automatic pcm_t mix_to_pcm(input mix_t mix);
    return {~mix[8], mix[7:0], 7'b0000000};
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S timing generator: BCLK divider, frame bit counter and LRCLK.
// Reports the falling-BCLK event, the frame wrap and the slot position of the bit about to be driven.
module i2s_clk_gen #(
  parameter int BCLK_DIV  = 7,
  parameter int SLOT_BITS = 32
) (
  input  logic                         clk,
  input  logic                         mrst_n,
  output logic                         bclk,
  output logic                         lrclk,
  output logic                         fall_evt,
  output logic                         wrap_evt,
  output logic                         right_half,
  output logic [$clog2(SLOT_BITS)-1:0] slot_pos
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int SLOT_W     = $clog2(SLOT_BITS);
  localparam int DIV_W      = $clog2(BCLK_DIV + 1);

  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [BIT_W-1:0] bit_cnt_inc;
  logic             bclk_reg, bclk_next;
  logic             lrclk_reg, lrclk_next;
  logic             div_wrap;
  logic             bit_wrap;

  always_comb begin
    div_cnt_next = div_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    bclk_next    = bclk_reg;
    lrclk_next   = lrclk_reg;

    div_wrap = (div_cnt_reg == DIV_W'(BCLK_DIV - 1));
    fall_evt = div_wrap && bclk_reg;
    bit_wrap = (bit_cnt_reg == BIT_W'(FRAME_BITS - 1));
    wrap_evt = fall_evt && bit_wrap;

    // Everything downstream is driven from the counter value that becomes current at this fall.
    bit_cnt_inc = bit_wrap ? '0 : bit_cnt_reg + BIT_W'(1);
    right_half  = (bit_cnt_inc >= BIT_W'(SLOT_BITS));
    slot_pos    = right_half ? SLOT_W'(bit_cnt_inc - BIT_W'(SLOT_BITS)) : SLOT_W'(bit_cnt_inc);

    div_cnt_next = div_wrap ? '0 : div_cnt_reg + DIV_W'(1);
    bclk_next    = bclk_reg ^ div_wrap;
    if (fall_evt) begin
      bit_cnt_next = bit_cnt_inc;
      lrclk_next   = right_half;
    end
  end

  always_ff @(posedge clk or negedge mrst_n) begin
    if (!mrst_n) begin
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      bclk_reg    <= 1'b0;
      lrclk_reg   <= 1'b0;
    end else begin
      div_cnt_reg <= div_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      bclk_reg    <= bclk_next;
      lrclk_reg   <= lrclk_next;
    end
  end

  assign bclk  = bclk_reg;
  assign lrclk = lrclk_reg;

endmodule

// File: rtl/i2s_audio_tx.sv
// I2S transmitter for the 9-bit excess-256 mixer outputs, one L/R pair captured per frame.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified framing instead of standard one-bit-delay I2S.
module i2s_audio_tx
  import audio_pkg::*;
#(
  parameter int BCLK_DIV  = 7,
  parameter int SLOT_BITS = I2S_SLOT_BITS_DEFAULT
) (
  input  logic                clk,
  input  logic                mrst_n,
  input  logic [MIX_BITS-1:0] mix_left,
  input  logic [MIX_BITS-1:0] mix_right,
  output logic                i2s_bclk,
  output logic                i2s_lrclk,
  output logic                i2s_sdata,
  output logic                sample_strobe
);

  localparam int          SLOT_W = $clog2(SLOT_BITS);
  localparam int          IDX_W  = $clog2(PCM_BITS);
  localparam logic [31:0] PCM_W  = 32'(PCM_BITS);

  logic              fall_evt;
  logic              wrap_evt;
  logic              right_half;
  logic [SLOT_W-1:0] slot_pos;
  logic [31:0]       pos_ext;

  pcm_t shadow_l_reg, shadow_l_next;
  pcm_t shadow_r_reg, shadow_r_next;
  pcm_t word;
  logic ser_bit;
  logic sdata_reg, sdata_next;
  logic strobe_reg, strobe_next;

  i2s_clk_gen #(
    .BCLK_DIV  (BCLK_DIV),
    .SLOT_BITS (SLOT_BITS)
  ) u_clk_gen (
    .clk        (clk),
    .mrst_n     (mrst_n),
    .bclk       (i2s_bclk),
    .lrclk      (i2s_lrclk),
    .fall_evt   (fall_evt),
    .wrap_evt   (wrap_evt),
    .right_half (right_half),
    .slot_pos   (slot_pos)
  );

  always_comb begin
    shadow_l_next = shadow_l_reg;
    shadow_r_next = shadow_r_reg;
    sdata_next    = sdata_reg;
    strobe_next   = wrap_evt;
    pos_ext       = 32'(slot_pos);
    word          = right_half ? shadow_r_reg : shadow_l_reg;
    ser_bit       = 1'b0;

    if (wrap_evt) begin
      shadow_l_next = mix_to_pcm(mix_left);
      shadow_r_next = mix_to_pcm(mix_right);
    end

`ifdef I2S_LEFT_JUSTIFIED_EN
    // MSB leaves on the wrap edge itself, so it must come from the sample being captured.
    if (wrap_evt) begin
      word = mix_to_pcm(mix_left);
    end
    if (pos_ext < PCM_W) begin
      ser_bit = word[IDX_W'(PCM_W - 32'd1 - pos_ext)];
    end
`else
    if (pos_ext >= 32'd1 && pos_ext <= PCM_W) begin
      ser_bit = word[IDX_W'(PCM_W - pos_ext)];
    end
`endif

    if (fall_evt) begin
      sdata_next = ser_bit;
    end
  end

  always_ff @(posedge clk or negedge mrst_n) begin
    if (!mrst_n) begin
      shadow_l_reg <= '0;
      shadow_r_reg <= '0;
      sdata_reg    <= 1'b0;
      strobe_reg   <= 1'b0;
    end else begin
      shadow_l_reg <= shadow_l_next;
      shadow_r_reg <= shadow_r_next;
      sdata_reg    <= sdata_next;
      strobe_reg   <= strobe_next;
    end
  end

  assign i2s_sdata     = sdata_reg;
  assign sample_strobe = strobe_reg;

endmodule
